alu_seq: RTL and testbench

Parametrised, handshaked successor to the single-cycle RV32I ALU. Keeps the 5-bit `Upr_ALU` operation encoding and adds two things:
- registered valid/ready interfaces on both sides;
- an iterative unsigned multiply/divide datapath for a subset of the RV32M operations.

It sits between the decode/operand-fetch stage and writeback. This lets the core stall on multi-cycle operations instead of requiring a single-cycle combinational path.

---
 rtl/alu_seq.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked RV32I-style ALU with an iterative unsigned multiplier
// and an optional restoring divider.
// Optional feature macro: ALU_SEQ_DIV_EN. When it is defined, the divider
// and the DIV state are built. When it is undefined, DIVU/REMU take the
// unlisted-opcode path and produce 0 after one cycle.
// The single-cycle class registers its result on the accept edge.
// MUL/MULHU/DIVU/REMU process one operand bit per cycle for WIDTH cycles.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       Upr_ALU,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out_ALU,
    output logic             C,
    output logic             busy
);

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b01000;
    localparam logic [4:0] OP_SLL   = 5'b00001;
    localparam logic [4:0] OP_SLTS  = 5'b00010;
    localparam logic [4:0] OP_SLTU  = 5'b00011;
    localparam logic [4:0] OP_XOR   = 5'b00100;
    localparam logic [4:0] OP_SRL   = 5'b00101;
    localparam logic [4:0] OP_SRA   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b00110;
    localparam logic [4:0] OP_AND   = 5'b00111;
    localparam logic [4:0] OP_EQ    = 5'b11000;
    localparam logic [4:0] OP_NE    = 5'b11001;
    localparam logic [4:0] OP_LTS   = 5'b11100;
    localparam logic [4:0] OP_GES   = 5'b11101;
    localparam logic [4:0] OP_LTU   = 5'b11110;
    localparam logic [4:0] OP_GEU   = 5'b11111;
    localparam logic [4:0] OP_MUL   = 5'b10000;
    localparam logic [4:0] OP_MULHU = 5'b10011;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [4:0] OP_DIVU  = 5'b10101;
    localparam logic [4:0] OP_REMU  = 5'b10111;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
`ifdef ALU_SEQ_DIV_EN
        ST_DIV  = 2'b10,
`endif
        ST_DONE = 2'b11
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    state_t                 start_state_s;
    logic                   in_ready_s;
    logic                   accept_s;
    logic                   is_mul_s;

    logic [SH_W-1:0]        sh_s;
    logic                   lts_s;
    logic                   ltu_s;
    logic [WIDTH-1:0]       sc_out_s;
    logic                   sc_c_s;

    logic [4:0]             op_r;
    logic [WIDTH-1:0]       a_r;
    logic [SH_W-1:0]        cnt_r;
    logic [2*WIDTH-1:0]     prod_r;
    logic [WIDTH:0]         mul_sum_s;
    logic [2*WIDTH-1:0]     prod_next_s;
    logic [WIDTH-1:0]       mul_res_s;

`ifdef ALU_SEQ_DIV_EN
    logic                   is_div_s;
    logic [WIDTH-1:0]       b_r;
    logic [WIDTH:0]         rem_r;
    logic [WIDTH-1:0]       quo_r;
    logic [WIDTH:0]         rem_shift_s;
    logic                   rem_ge_s;
    logic [WIDTH:0]         rem_next_s;
    logic [WIDTH-1:0]       quo_next_s;
    logic [WIDTH-1:0]       div_res_s;
`endif

    logic [WIDTH-1:0]       out_alu_r;
    logic                   c_r;
    logic                   out_valid_r;

    assign in_ready_s = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
    assign accept_s   = in_valid && in_ready_s;
    assign in_ready   = in_ready_s;
    assign busy       = (state_r == ST_MUL)
`ifdef ALU_SEQ_DIV_EN
                        || (state_r == ST_DIV)
`endif
                        ;
    assign out_valid  = out_valid_r;
    assign Out_ALU    = out_alu_r;
    assign C          = c_r;

    assign sh_s     = B[SH_W-1:0];
    assign lts_s    = $signed(A) < $signed(B);
    assign ltu_s    = A < B;
    assign is_mul_s = (Upr_ALU == OP_MUL) || (Upr_ALU == OP_MULHU);
`ifdef ALU_SEQ_DIV_EN
    assign is_div_s = (Upr_ALU == OP_DIVU) || (Upr_ALU == OP_REMU);
`endif

    // Single-cycle result and branch flag computed straight from the live operands.
    always_comb begin
        sc_out_s = {WIDTH{1'b0}};
        sc_c_s   = 1'b0;
        case (Upr_ALU)
            OP_ADD:  sc_out_s = A + B;
            OP_SUB:  sc_out_s = A - B;
            OP_SLL:  sc_out_s = A << sh_s;
            OP_SLTS: sc_out_s = {{(WIDTH-1){1'b0}}, lts_s};
            OP_SLTU: sc_out_s = {{(WIDTH-1){1'b0}}, ltu_s};
            OP_XOR:  sc_out_s = A ^ B;
            OP_SRL:  sc_out_s = A >> sh_s;
            OP_SRA:  sc_out_s = $signed(A) >>> sh_s;
            OP_OR:   sc_out_s = A | B;
            OP_AND:  sc_out_s = A & B;
            OP_EQ:   sc_c_s   = (A == B);
            OP_NE:   sc_c_s   = (A != B);
            OP_LTS:  sc_c_s   = lts_s;
            OP_GES:  sc_c_s   = !lts_s;
            OP_LTU:  sc_c_s   = ltu_s;
            OP_GEU:  sc_c_s   = !ltu_s;
            default: sc_out_s = {WIDTH{1'b0}};
        endcase
    end

    // Pick the state an accepted opcode starts in.
    always_comb begin
        start_state_s = ST_DONE;
        if (is_mul_s) begin
            start_state_s = ST_MUL;
        end
`ifdef ALU_SEQ_DIV_EN
        else if (is_div_s) begin
            start_state_s = ST_DIV;
        end
`endif
        else begin
            start_state_s = ST_DONE;
        end
    end

    // One shift-add multiply step: add the multiplicand if the LSB is set, shift right.
    always_comb begin
        mul_sum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]}
                    + (prod_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
        prod_next_s = {mul_sum_s, prod_r[WIDTH-1:1]};
        if (op_r == OP_MULHU) begin
            mul_res_s = prod_next_s[2*WIDTH-1:WIDTH];
        end else begin
            mul_res_s = prod_next_s[WIDTH-1:0];
        end
    end

`ifdef ALU_SEQ_DIV_EN
    // One restoring divide step; a zero divisor always subtracts and yields all-ones / A.
    always_comb begin
        rem_shift_s = (rem_r << 1) | {{WIDTH{1'b0}}, quo_r[WIDTH-1]};
        rem_ge_s    = rem_shift_s >= {1'b0, b_r};
        if (rem_ge_s) begin
            rem_next_s = rem_shift_s - {1'b0, b_r};
        end else begin
            rem_next_s = rem_shift_s;
        end
        quo_next_s = {quo_r[WIDTH-2:0], rem_ge_s};
        if (op_r == OP_REMU) begin
            div_res_s = rem_next_s[WIDTH-1:0];
        end else begin
            div_res_s = quo_next_s;
        end
    end
`endif

    // Next-state logic for the control FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next_s = start_state_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (cnt_r == {SH_W{1'b0}}) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_MUL;
                end
            end
`ifdef ALU_SEQ_DIV_EN
            ST_DIV: begin
                if (cnt_r == {SH_W{1'b0}}) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DIV;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        state_next_s = start_state_s;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, iterative datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r        <= 5'b00000;
            a_r         <= {WIDTH{1'b0}};
            cnt_r       <= {SH_W{1'b0}};
            prod_r      <= {(2*WIDTH){1'b0}};
`ifdef ALU_SEQ_DIV_EN
            b_r         <= {WIDTH{1'b0}};
            rem_r       <= {(WIDTH+1){1'b0}};
            quo_r       <= {WIDTH{1'b0}};
`endif
            out_alu_r   <= {WIDTH{1'b0}};
            c_r         <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            op_r   <= Upr_ALU;
            a_r    <= A;
            cnt_r  <= SH_W'(WIDTH-1);
            prod_r <= {{WIDTH{1'b0}}, B};
`ifdef ALU_SEQ_DIV_EN
            b_r    <= B;
            rem_r  <= {(WIDTH+1){1'b0}};
            quo_r  <= A;
`endif
            if (start_state_s == ST_DONE) begin
                out_alu_r   <= sc_out_s;
                c_r         <= sc_c_s;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if ((state_r == ST_DONE) && out_ready) begin
            out_valid_r <= 1'b0;
        end else if (state_r == ST_MUL) begin
            prod_r <= prod_next_s;
            if (cnt_r == {SH_W{1'b0}}) begin
                out_alu_r   <= mul_res_s;
                c_r         <= 1'b0;
                out_valid_r <= 1'b1;
            end else begin
                cnt_r <= cnt_r - SH_W'(1);
            end
        end
`ifdef ALU_SEQ_DIV_EN
        else if (state_r == ST_DIV) begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
            if (cnt_r == {SH_W{1'b0}}) begin
                out_alu_r   <= div_res_s;
                c_r         <= 1'b0;
                out_valid_r <= 1'b1;
            end else begin
                cnt_r <= cnt_r - SH_W'(1);
            end
        end
`endif
        else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=32): a transaction-level reference model plus
// directed test-plan scenarios and randomized traffic. Honours ALU_SEQ_DIV_EN.
module tb_alu_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [4:0]    op = 5'b00000;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_alu;
    logic          c;
    logic          busy;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .Upr_ALU(op), .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready),
        .Out_ALU(out_alu), .C(c), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, wanted %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: what an opcode must return, from the instruction definitions.
    function automatic void ref_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] r, output logic cc, output logic iter);
        longint unsigned p;
        logic [4:0] s;
        p = 64'(x) * 64'(y);
        s = y[4:0];
        r = 32'd0; cc = 1'b0; iter = 1'b0;
        case (o)
            5'b00000: r = x + y;
            5'b01000: r = x - y;
            5'b00001: r = x << s;
            5'b00010: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            5'b00011: r = (x < y) ? 32'd1 : 32'd0;
            5'b00100: r = x ^ y;
            5'b00101: r = x >> s;
            5'b01101: r = 32'($signed(x) >>> s);
            5'b00110: r = x | y;
            5'b00111: r = x & y;
            5'b11000: cc = (x == y);
            5'b11001: cc = (x != y);
            5'b11100: cc = ($signed(x) < $signed(y));
            5'b11101: cc = !($signed(x) < $signed(y));
            5'b11110: cc = (x < y);
            5'b11111: cc = !(x < y);
            5'b10000: begin iter = 1'b1; r = p[31:0];  end
            5'b10011: begin iter = 1'b1; r = p[63:32]; end
`ifdef ALU_SEQ_DIV_EN
            5'b10101: begin iter = 1'b1; r = (y == 32'd0) ? 32'hFFFF_FFFF : x / y; end
            5'b10111: begin iter = 1'b1; r = (y == 32'd0) ? x : x % y; end
`endif
            default: r = 32'd0;
        endcase
    endfunction

    // Transaction model: one held result, and an in-flight countdown for iterative ops.
    logic        m_valid = 1'b0;
    logic [31:0] m_out = '0;
    logic        m_c = 1'b0;
    int          m_cd = 0;
    logic [31:0] m_pend = '0;

    initial begin
        logic        acc;
        logic [31:0] r;
        logic        cc;
        logic        it;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_valid = 1'b0; m_out = '0; m_c = 1'b0; m_cd = 0;
            end else begin
                acc = in_valid && (m_cd == 0) && (!m_valid || out_ready);
                if (m_valid && out_ready) m_valid = 1'b0;
                if (m_cd > 0) begin
                    m_cd--;
                    if (m_cd == 0) begin m_valid = 1'b1; m_out = m_pend; m_c = 1'b0; end
                end
                if (acc) begin
                    ref_op(op, a, b, r, cc, it);
                    if (it) begin m_cd = W; m_pend = r; end
                    else begin m_valid = 1'b1; m_out = r; m_c = cc; end
                end
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk1("out_valid", out_valid, m_valid);
            chk1("busy", busy, m_cd > 0);
            chk1("in_ready", in_ready, (m_cd == 0) && (!m_valid || out_ready));
            if (m_valid) begin
                chk("Out_ALU", out_alu, m_out);
                chk1("C", c, m_c);
            end
        end
    end

    // Issue one op with out_ready=1 and measure accept-to-result latency and busy cycles.
    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output int lat, output int bcnt);
        @(posedge clk); #2;
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        lat = 0; bcnt = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) in_valid = 1'b0;
            if (busy) bcnt++;
        end while (!out_valid && lat < 100);
        res = out_alu;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom % 6)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            4: return 32'($urandom % 8);
            default: return 32'($urandom);
        endcase
    endfunction

    logic [4:0] op_tbl [24] = '{5'b00000, 5'b01000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                               5'b00101, 5'b01101, 5'b00110, 5'b00111, 5'b11000, 5'b11001,
                               5'b11100, 5'b11101, 5'b11110, 5'b11111, 5'b10000, 5'b10011,
                               5'b10101, 5'b10111, 5'b01111, 5'b10001, 5'b11010, 5'b00000};

    logic [4:0]  s_op [6] = '{5'b00000, 5'b01101, 5'b00010, 5'b11110, 5'b11100, 5'b11111};
    logic [31:0] s_a  [6] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] s_b  [6] = '{32'd1, 32'h21, 32'd1, 32'd1, 32'd1, 32'd5};
    logic [31:0] s_r  [6] = '{32'd0, 32'hC000_0000, 32'd1, 32'd0, 32'd0, 32'd0};
    logic        s_c  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        logic [31:0] res;
        logic        cc;
        logic        it;
        int          lat;
        int          bcnt;

        // Pin the reference model against hand-computed values.
        ref_op(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, cc, it); chk("model_mulhu", res, 32'hFFFF_FFFE);
        ref_op(5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, cc, it); chk("model_mul", res, 32'h0000_0001);
        ref_op(5'b01101, 32'h8000_0000, 32'h21, res, cc, it);       chk("model_sra", res, 32'hC000_0000);
        ref_op(5'b11110, 32'hFFFF_FFFF, 32'd1, res, cc, it);        chk1("model_ltu", cc, 1'b0);

        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk1("reset_out_valid", out_valid, 1'b0);
        chk("reset_Out_ALU", out_alu, 32'd0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_C", c, 1'b0);

        // Reset five cycles into a MUL aborts it.
        @(posedge clk); #2;
        op = 5'b10000; a = 32'd7; b = 32'd6; in_valid = 1'b1;
        @(posedge clk); #2 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk1("abort_out_valid", out_valid, 1'b0);
        chk("abort_Out_ALU", out_alu, 32'd0);
        chk1("abort_busy", busy, 1'b0);
        @(posedge clk); #2 rst = 1'b0;

        issue(5'b10000, 32'd7, 32'd6, res, lat, bcnt);
        chk("mul_7x6", res, 32'd42);
        chk("mul_7x6_latency", 32'(lat), 32'd33);

        // Back-to-back single-cycle stream, one result per cycle.
        for (int i = 0; i <= 6; i++) begin
            @(posedge clk); #1;
            if (i > 0) begin
                chk1("stream_valid", out_valid, 1'b1);
                chk("stream_result", out_alu, s_r[i-1]);
                chk1("stream_C", c, s_c[i-1]);
            end
            #1;
            if (i < 6) begin
                op = s_op[i]; a = s_a[i]; b = s_b[i]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        repeat (2) @(posedge clk);

        issue(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, bcnt);
        chk("mulhu_ones", res, 32'hFFFF_FFFE);
        chk("mulhu_latency", 32'(lat), 32'd33);
        chk("mulhu_busy_cycles", 32'(bcnt), 32'd32);
        issue(5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, bcnt);
        chk("mul_ones", res, 32'h0000_0001);
        chk("mul_latency", 32'(lat), 32'd33);
        chk("mul_busy_cycles", 32'(bcnt), 32'd32);

`ifdef ALU_SEQ_DIV_EN
        issue(5'b10101, 32'd100, 32'd7, res, lat, bcnt);
        chk("divu_100_7", res, 32'd14);
        chk("divu_latency", 32'(lat), 32'd33);
        issue(5'b10111, 32'd100, 32'd7, res, lat, bcnt);
        chk("remu_100_7", res, 32'd2);
        issue(5'b10101, 32'd5, 32'd0, res, lat, bcnt);
        chk("divu_by_zero", res, 32'hFFFF_FFFF);
        issue(5'b10111, 32'd5, 32'd0, res, lat, bcnt);
        chk("remu_by_zero", res, 32'd5);
`else
        issue(5'b10101, 32'd100, 32'd7, res, lat, bcnt);
        chk("divu_disabled", res, 32'd0);
        chk("divu_disabled_latency", 32'(lat), 32'd1);
        chk("divu_disabled_busy", 32'(bcnt), 32'd0);
`endif
        repeat (2) @(posedge clk);

        // Backpressure: result frozen, SUB held off, then accepted on release.
        #2;
        out_ready = 1'b0; op = 5'b00000; a = 32'd3; b = 32'd4; in_valid = 1'b1;
        @(posedge clk); #2;
        op = 5'b01000; a = 32'd9; b = 32'd5;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("bp_hold_result", out_alu, 32'd7);
            chk1("bp_in_ready", in_ready, 1'b0);
            chk1("bp_valid", out_valid, 1'b1);
        end
        #1 out_ready = 1'b1;
        #1 chk1("bp_release_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        chk1("bp_sub_valid", out_valid, 1'b1);
        chk("bp_sub_result", out_alu, 32'd4);
        #1 in_valid = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #2;
            in_valid  = ($urandom % 3) != 0;
            op        = op_tbl[$urandom % 24];
            a         = rnd_val();
            b         = rnd_val();
            out_ready = ($urandom % 4) != 0;
        end
        #1 in_valid = 1'b0; out_ready = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
